// File: rtl/cci_test_csr_ctr_pkg.sv
// Shared constants and types for the CSR-mapped event counter bank.
package cci_test_csr_ctr_pkg;

  // Control word bit positions
  localparam int CTRL_SNAP     = 0;
  localparam int CTRL_CLR      = 1;
  localparam int CTRL_FRZ      = 2;
  localparam int CTRL_CLR_DROP = 3;

  // Status word field offsets
  localparam int STAT_FRZ      = 0;
  localparam int STAT_OVF      = 1;
  localparam int STAT_DROP     = 2;
  localparam int STAT_CTRW_LSB = 40;
  localparam int STAT_NCTR_LSB = 48;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
  } t_csr_rsp;

  // Assemble the status word from its flag and geometry fields.
  function automatic logic [63:0] pack_status(input logic [15:0] num_ctrs,
                                              input logic [7:0]  ctr_width,
                                              input logic        drop,
                                              input logic        ovf,
                                              input logic        frz);
    logic [63:0] v;
    v = '0;
    v[STAT_NCTR_LSB +: 16] = num_ctrs;
    v[STAT_CTRW_LSB +: 8]  = ctr_width;
    v[STAT_DROP]           = drop;
    v[STAT_OVF]            = ovf;
    v[STAT_FRZ]            = frz;
    return v;
  endfunction

endpackage

// File: rtl/cci_test_csr_rsp_fifo.sv
// Small response FIFO for locally generated CSR read responses.
// Full/empty are registered; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module cci_test_csr_rsp_fifo
  import cci_test_csr_ctr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  t_csr_rsp i_push_data,
  input  logic     i_pop,
  output t_csr_rsp o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  t_csr_rsp        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_full;
  logic            r_empty;

  logic            w_pop_ok;
  logic            w_push_ok;
  logic [AW:0]     w_count_nxt;

  assign w_pop_ok  = i_pop && !r_empty;
  assign w_push_ok = i_push && (!r_full || w_pop_ok);

  // Next occupancy from accepted push/pop
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok)
      w_count_nxt = r_count + (AW+1)'(1);
    else if (!w_push_ok && w_pop_ok)
      w_count_nxt = r_count - (AW+1)'(1);
  end

  // Pointer, occupancy and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage write; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/cci_test_csr_ctr_bank.sv
// MMIO-mapped bank of event counters with snapshot/clear/freeze control.
// Local read responses are queued and merged behind the AFU's own read
// responses, which always take priority on the FIU side.
module cci_test_csr_ctr_bank
  import cci_test_csr_ctr_pkg::*;
#(
  parameter int NUM_CTRS       = 16,
  parameter int CTR_WIDTH      = 48,
  parameter int INC_WIDTH      = 3,
  parameter int BASE_CSR_IDX   = 64,
  parameter int RSP_FIFO_DEPTH = 4,
  parameter int SATURATE       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mmio_rd_valid,
  input  logic                          mmio_wr_valid,
  input  logic [15:0]                   mmio_addr,
  input  logic [8:0]                    mmio_tid,
  input  logic [63:0]                   mmio_wr_data,
  input  logic [NUM_CTRS*INC_WIDTH-1:0] ctr_inc,
  input  logic                          afu_rd_rsp_valid,
  input  logic [8:0]                    afu_rd_rsp_tid,
  input  logic [63:0]                   afu_rd_rsp_data,
  output logic                          fiu_rd_rsp_valid,
  output logic [8:0]                    fiu_rd_rsp_tid,
  output logic [63:0]                   fiu_rd_rsp_data
);

  localparam int          OFF_W       = 8;
  localparam logic [14:0] LP_BASE_IDX = 15'(BASE_CSR_IDX);
  localparam logic [14:0] LP_LAST_IDX = 15'(BASE_CSR_IDX + NUM_CTRS);

  // Address decode
  logic [14:0]      w_csr_idx;
  logic             w_hit;
  logic [OFF_W-1:0] w_off;
  logic             w_ctrl_wr;
  logic             w_snap;
  logic             w_clr;
  logic             w_clr_drop;

  assign w_csr_idx  = mmio_addr[15:1];
  assign w_hit      = (w_csr_idx >= LP_BASE_IDX) && (w_csr_idx <= LP_LAST_IDX);
  assign w_off      = OFF_W'(w_csr_idx - LP_BASE_IDX);
  assign w_ctrl_wr  = mmio_wr_valid && w_hit && (w_csr_idx == LP_BASE_IDX);
  assign w_snap     = w_ctrl_wr && mmio_wr_data[CTRL_SNAP];
  assign w_clr      = w_ctrl_wr && mmio_wr_data[CTRL_CLR];
  assign w_clr_drop = w_ctrl_wr && mmio_wr_data[CTRL_CLR_DROP];

  // Address bit 0 and upper control bits carry no meaning here
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, mmio_addr[0], mmio_wr_data[63:4]};

  // Control/status flags
  logic r_frozen;
  logic r_ctr_ovf;
  logic r_rsp_drop;

  // Counter array
  logic [NUM_CTRS-1:0]                w_carry;
  logic [NUM_CTRS-1:0][CTR_WIDTH-1:0] w_shadow;

  for (genvar gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
    logic [CTR_WIDTH-1:0] r_live;
    logic [CTR_WIDTH-1:0] r_shadow;
    logic [CTR_WIDTH:0]   w_sum;
    logic [CTR_WIDTH-1:0] w_live_nxt;

    assign w_sum        = {1'b0, r_live} + (CTR_WIDTH+1)'(ctr_inc[gi*INC_WIDTH +: INC_WIDTH]);
    assign w_carry[gi]  = w_sum[CTR_WIDTH];
    assign w_shadow[gi] = r_shadow;

    if (SATURATE != 0) begin : g_sat
      assign w_live_nxt = w_sum[CTR_WIDTH] ? '1 : w_sum[CTR_WIDTH-1:0];
    end else begin : g_wrap
      assign w_live_nxt = w_sum[CTR_WIDTH-1:0];
    end

    // Snapshot captures the pre-clear, pre-increment value; clear beats increment
    always_ff @(posedge clk) begin
      if (reset) begin
        r_live   <= '0;
        r_shadow <= '0;
      end else begin
        if (w_snap) r_shadow <= r_live;
        if (w_clr)
          r_live <= '0;
        else if (!r_frozen)
          r_live <= w_live_nxt;
      end
    end
  end

  // Read request stage: decode registered one cycle after the request
  logic             r_rd_vld;
  logic [8:0]       r_rd_tid;
  logic [OFF_W-1:0] r_rd_off;

  // Capture decoded read requests; misses vanish here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= 1'b0;
      r_rd_tid <= '0;
      r_rd_off <= '0;
    end else begin
      r_rd_vld <= mmio_rd_valid && w_hit;
      r_rd_tid <= mmio_tid;
      r_rd_off <= w_off;
    end
  end

  // Read data mux: offset 0 is status, offset 1+i is shadow i
  logic [63:0] w_rd_data;
  always_comb begin
    w_rd_data = '0;
    if (r_rd_off == '0) begin
      w_rd_data = pack_status(16'(NUM_CTRS), 8'(CTR_WIDTH), r_rsp_drop, r_ctr_ovf, r_frozen);
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        if (r_rd_off == OFF_W'(i + 1)) w_rd_data = 64'(w_shadow[i]);
      end
    end
  end

  // Response FIFO and merge
  t_csr_rsp w_push_rsp;
  t_csr_rsp w_head;
  logic     w_fifo_full;
  logic     w_fifo_empty;
  logic     w_pop;
  logic     w_drop;

  assign w_push_rsp.tid  = r_rd_tid;
  assign w_push_rsp.data = w_rd_data;
  assign w_pop           = !afu_rd_rsp_valid && !w_fifo_empty;
  assign w_drop          = r_rd_vld && w_fifo_full && !w_pop;

  cci_test_csr_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_rd_vld),
    .i_push_data (w_push_rsp),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Sticky flags and freeze control; a drop in the clearing cycle stays visible
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frozen   <= 1'b0;
      r_ctr_ovf  <= 1'b0;
      r_rsp_drop <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_frozen <= mmio_wr_data[CTRL_FRZ];
      if (w_clr)
        r_ctr_ovf <= 1'b0;
      else if (!r_frozen && |w_carry)
        r_ctr_ovf <= 1'b1;
      if (w_drop)
        r_rsp_drop <= 1'b1;
      else if (w_clr_drop)
        r_rsp_drop <= 1'b0;
    end
  end

  // Output register: AFU response wins, otherwise drain the FIFO head
  logic        r_fiu_vld;
  logic [8:0]  r_fiu_tid;
  logic [63:0] r_fiu_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fiu_vld  <= 1'b0;
      r_fiu_tid  <= '0;
      r_fiu_data <= '0;
    end else if (afu_rd_rsp_valid) begin
      r_fiu_vld  <= 1'b1;
      r_fiu_tid  <= afu_rd_rsp_tid;
      r_fiu_data <= afu_rd_rsp_data;
    end else if (!w_fifo_empty) begin
      r_fiu_vld  <= 1'b1;
      r_fiu_tid  <= w_head.tid;
      r_fiu_data <= w_head.data;
    end else begin
      r_fiu_vld  <= 1'b0;
    end
  end

  assign fiu_rd_rsp_valid = r_fiu_vld;
  assign fiu_rd_rsp_tid   = r_fiu_tid;
  assign fiu_rd_rsp_data  = r_fiu_data;

endmodule

// File: tb/tb_cci_test_csr_ctr_bank.sv
// Directed bench for the CSR counter bank: three instances share stimulus
// (default wrap/48-bit, 8-bit wrap with 2-deep FIFO, 8-bit saturating).
module tb_cci_test_csr_ctr_bank;

  localparam int NC   = 16;
  localparam int IW   = 3;
  localparam int BASE = 64;

  localparam logic [63:0] ST0 = 64'h0010_3000_0000_0000;
  localparam logic [63:0] ST8 = 64'h0010_0800_0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              mmio_rd_valid;
  logic              mmio_wr_valid;
  logic [15:0]       mmio_addr;
  logic [8:0]        mmio_tid;
  logic [63:0]       mmio_wr_data;
  logic [NC*IW-1:0]  ctr_inc;
  logic              afu_rd_rsp_valid;
  logic [8:0]        afu_rd_rsp_tid;
  logic [63:0]       afu_rd_rsp_data;

  logic              v0, v1, v2;
  logic [8:0]        t0, t1, t2;
  logic [63:0]       d0, d1, d2;

  always #5 clk = ~clk;

  cci_test_csr_ctr_bank #(.NUM_CTRS(NC), .CTR_WIDTH(48), .INC_WIDTH(IW), .BASE_CSR_IDX(BASE),
                          .RSP_FIFO_DEPTH(4), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data), .ctr_inc(ctr_inc),
    .afu_rd_rsp_valid(afu_rd_rsp_valid), .afu_rd_rsp_tid(afu_rd_rsp_tid), .afu_rd_rsp_data(afu_rd_rsp_data),
    .fiu_rd_rsp_valid(v0), .fiu_rd_rsp_tid(t0), .fiu_rd_rsp_data(d0));

  cci_test_csr_ctr_bank #(.NUM_CTRS(NC), .CTR_WIDTH(8), .INC_WIDTH(IW), .BASE_CSR_IDX(BASE),
                          .RSP_FIFO_DEPTH(2), .SATURATE(0)) dut1 (
    .clk(clk), .reset(reset), .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data), .ctr_inc(ctr_inc),
    .afu_rd_rsp_valid(afu_rd_rsp_valid), .afu_rd_rsp_tid(afu_rd_rsp_tid), .afu_rd_rsp_data(afu_rd_rsp_data),
    .fiu_rd_rsp_valid(v1), .fiu_rd_rsp_tid(t1), .fiu_rd_rsp_data(d1));

  cci_test_csr_ctr_bank #(.NUM_CTRS(NC), .CTR_WIDTH(8), .INC_WIDTH(IW), .BASE_CSR_IDX(BASE),
                          .RSP_FIFO_DEPTH(4), .SATURATE(1)) dut2 (
    .clk(clk), .reset(reset), .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data), .ctr_inc(ctr_inc),
    .afu_rd_rsp_valid(afu_rd_rsp_valid), .afu_rd_rsp_tid(afu_rd_rsp_tid), .afu_rd_rsp_data(afu_rd_rsp_data),
    .fiu_rd_rsp_valid(v2), .fiu_rd_rsp_tid(t2), .fiu_rd_rsp_data(d2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int req_cyc = 0;

  logic [72:0] q0[$];
  logic [72:0] q1[$];
  logic [72:0] q2[$];
  int          c0[$];

  always @(posedge clk) cyc++;

  // Response monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (v0) begin q0.push_back({t0, d0}); c0.push_back(cyc); end
    if (v1) q1.push_back({t1, d1});
    if (v2) q2.push_back({t2, d2});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [72:0] qget(input int which, input int pos);
    case (which)
      0:       return q0[pos];
      1:       return q1[pos];
      default: return q2[pos];
    endcase
  endfunction

  function automatic int count_tid(input int which, input int lo, input int hi);
    int n = 0;
    for (int k = 0; k < qsize(which); k++) begin
      logic [72:0] e;
      e = qget(which, k);
      if (int'(e[72:64]) >= lo && int'(e[72:64]) <= hi) n++;
    end
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); q2.delete(); c0.delete();
  endtask

  task automatic set_inc(input int idx, input logic [IW-1:0] v);
    ctr_inc = '0;
    ctr_inc[idx*IW +: IW] = v;
  endtask

  task automatic csr_wr(input int idx, input logic [63:0] d);
    mmio_wr_valid = 1'b1;
    mmio_addr     = {15'(idx), 1'b0};
    mmio_wr_data  = d;
    tick(1);
    mmio_wr_valid = 1'b0;
  endtask

  task automatic csr_rd(input int idx, input logic [8:0] tid, input logic lsb);
    mmio_rd_valid = 1'b1;
    mmio_addr     = {15'(idx), lsb};
    mmio_tid      = tid;
    req_cyc       = cyc;
    tick(1);
    mmio_rd_valid = 1'b0;
  endtask

  // Bounded wait for n responses on one instance
  task automatic wait_q(input int which, input int n);
    for (int k = 0; k < 40; k++) begin
      if (qsize(which) >= n) break;
      tick(1);
    end
  endtask

  task automatic chk_rsp(input string tag, input int which, input int pos,
                         input logic [8:0] tid, input logic [63:0] data);
    logic [72:0] e;
    if (qsize(which) <= pos) begin
      check({tag, "_count"}, 64'(qsize(which)), 64'(pos + 1));
    end else begin
      e = qget(which, pos);
      check({tag, "_tid"}, 64'(e[72:64]), 64'(tid));
      check({tag, "_data"}, e[63:0], data);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mmio_rd_valid = 1'b0; mmio_wr_valid = 1'b0; mmio_addr = '0;
    mmio_tid = '0; mmio_wr_data = '0; ctr_inc = '0;
    afu_rd_rsp_valid = 1'b0; afu_rd_rsp_tid = '0; afu_rd_rsp_data = '0;

    // Reset state
    tick(3);
    check("rst_valid", 64'(v0), 64'd0);
    check("rst_tid",   64'(t0), 64'd0);
    check("rst_data",  d0,      64'd0);
    reset = 1'b0;
    tick(1);
    clear_q();
    csr_rd(BASE, 9'h001, 1'b0);
    wait_q(0, 1); tick(1);
    chk_rsp("rst_status0", 0, 0, 9'h001, ST0);
    chk_rsp("rst_status1", 1, 0, 9'h001, ST8);

    // 1: ten increments, snapshot, read with latency check
    set_inc(3, 3'd1);
    tick(10);
    ctr_inc = '0;
    csr_wr(BASE, 64'h1);
    clear_q();
    csr_rd(BASE + 4, 9'h02A, 1'b0);
    wait_q(0, 1);
    chk_rsp("t1_ctr3", 0, 0, 9'h02A, 64'd10);
    if (c0.size() > 0) check("t1_latency", 64'(c0[0] - req_cyc), 64'd3);

    // 2: AFU responses win; local responses follow in order
    clear_q();
    for (int k = 1; k <= 5; k++) begin
      afu_rd_rsp_valid = 1'b1;
      afu_rd_rsp_tid   = 9'(k);
      afu_rd_rsp_data  = 64'h0000_A000 + 64'(k);
      mmio_rd_valid    = (k <= 2);
      mmio_addr        = {15'(BASE + 4), 1'b0};
      mmio_tid         = (k == 1) ? 9'h008 : 9'h009;
      tick(1);
    end
    afu_rd_rsp_valid = 1'b0; mmio_rd_valid = 1'b0;
    wait_q(0, 7); tick(2);
    check("t2_count", 64'(q0.size()), 64'd7);
    for (int k = 1; k <= 5; k++) chk_rsp("t2_afu", 0, k - 1, 9'(k), 64'h0000_A000 + 64'(k));
    chk_rsp("t2_loc8", 0, 5, 9'h008, 64'd10);
    chk_rsp("t2_loc9", 0, 6, 9'h009, 64'd10);

    // 3: 300 increments on 48-bit, 8-bit wrap and 8-bit saturating banks
    csr_wr(BASE, 64'h2);
    set_inc(0, 3'd6);
    tick(50);
    ctr_inc = '0;
    csr_wr(BASE, 64'h1);
    clear_q();
    csr_rd(BASE + 1, 9'h011, 1'b0);
    csr_rd(BASE, 9'h012, 1'b0);
    wait_q(0, 2); tick(1);
    chk_rsp("t3_ctr48", 0, 0, 9'h011, 64'd300);
    chk_rsp("t3_wrap8", 1, 0, 9'h011, 64'd44);
    chk_rsp("t3_sat8",  2, 0, 9'h011, 64'd255);
    chk_rsp("t3_st48",  0, 1, 9'h012, ST0);
    chk_rsp("t3_stwrp", 1, 1, 9'h012, ST8 | 64'h2);
    chk_rsp("t3_stsat", 2, 1, 9'h012, ST8 | 64'h2);

    // 4: snapshot+clear, clear+increment, snapshot+increment
    csr_wr(BASE, 64'h2);
    set_inc(5, 3'd1);
    tick(7);
    ctr_inc = '0;
    clear_q();
    csr_wr(BASE, 64'h3);
    csr_rd(BASE + 6, 9'h040, 1'b0);
    csr_wr(BASE, 64'h1);
    csr_rd(BASE + 6, 9'h041, 1'b0);
    set_inc(5, 3'd5);
    csr_wr(BASE, 64'h2);
    ctr_inc = '0;
    csr_wr(BASE, 64'h1);
    csr_rd(BASE + 6, 9'h042, 1'b0);
    set_inc(5, 3'd3);
    csr_wr(BASE, 64'h1);
    ctr_inc = '0;
    csr_rd(BASE + 6, 9'h043, 1'b0);
    csr_wr(BASE, 64'h1);
    csr_rd(BASE + 6, 9'h044, 1'b0);
    wait_q(0, 5);
    chk_rsp("t4_snapclr", 0, 0, 9'h040, 64'd7);
    chk_rsp("t4_livezero", 0, 1, 9'h041, 64'd0);
    chk_rsp("t4_clrinc",  0, 2, 9'h042, 64'd0);
    chk_rsp("t4_snapinc", 0, 3, 9'h043, 64'd0);
    chk_rsp("t4_after",   0, 4, 9'h044, 64'd3);

    // 5: AFU blocks draining; third local response overflows the 2-deep FIFO
    clear_q();
    for (int k = 0; k < 7; k++) begin
      afu_rd_rsp_valid = 1'b1;
      afu_rd_rsp_tid   = 9'h100 + 9'(k);
      afu_rd_rsp_data  = '0;
      mmio_rd_valid    = (k < 3);
      mmio_addr        = {15'(BASE + 1), 1'b0};
      mmio_tid         = 9'h011 + 9'(k);
      tick(1);
    end
    afu_rd_rsp_valid = 1'b0; mmio_rd_valid = 1'b0;
    tick(10);
    check("t5_kept2",  64'(count_tid(1, 'h11, 'h13)), 64'd2);
    check("t5_kept4",  64'(count_tid(0, 'h11, 'h13)), 64'd3);
    chk_rsp("t5_order", 1, 7, 9'h011, 64'd0);
    chk_rsp("t5_order2", 1, 8, 9'h012, 64'd0);
    clear_q();
    csr_rd(BASE, 9'h020, 1'b0);
    wait_q(1, 1); tick(1);
    chk_rsp("t5_drop1", 1, 0, 9'h020, ST8 | 64'h4);
    chk_rsp("t5_nodrop", 0, 0, 9'h020, ST0);
    csr_wr(BASE, 64'h8);
    clear_q();
    csr_rd(BASE, 9'h021, 1'b0);
    wait_q(1, 1);
    chk_rsp("t5_dropclr", 1, 0, 9'h021, ST8);

    // 6: freeze, ignored counter writes, address LSB, decode misses
    csr_wr(BASE, 64'h2);
    set_inc(7, 3'd1);
    tick(2);
    ctr_inc = '0;
    csr_wr(BASE, 64'h4);
    set_inc(7, 3'd1);
    tick(20);
    ctr_inc = '0;
    csr_wr(BASE + 8, 64'hFF);
    csr_wr(BASE, 64'h5);
    clear_q();
    csr_rd(BASE + 8, 9'h030, 1'b0);
    csr_rd(BASE, 9'h031, 1'b0);
    csr_rd(BASE + 8, 9'h032, 1'b1);
    wait_q(0, 3);
    chk_rsp("t6_frozen", 0, 0, 9'h030, 64'd2);
    chk_rsp("t6_status", 0, 1, 9'h031, ST0 | 64'h1);
    chk_rsp("t6_lsb",    0, 2, 9'h032, 64'd2);
    csr_wr(BASE, 64'h0);
    clear_q();
    csr_rd(BASE + NC + 1, 9'h033, 1'b0);
    csr_rd(BASE - 1, 9'h034, 1'b0);
    tick(10);
    check("t6_miss", 64'(q0.size()), 64'd0);

    // 7: reset while local responses are queued discards them
    clear_q();
    for (int k = 0; k < 4; k++) begin
      afu_rd_rsp_valid = 1'b1;
      afu_rd_rsp_tid   = 9'h150 + 9'(k);
      mmio_rd_valid    = (k < 2);
      mmio_addr        = {15'(BASE + 1), 1'b0};
      mmio_tid         = 9'h061 + 9'(k);
      tick(1);
    end
    afu_rd_rsp_valid = 1'b0; mmio_rd_valid = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    check("t7_discard", 64'(count_tid(0, 'h61, 'h62)), 64'd0);
    check("t7_afu",     64'(count_tid(0, 'h150, 'h153)), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
